error_target_stack: RTL and testbench
=====================================

# error_target_stack

Parametrised exception-capture unit for the multi-cycle MIPS core. It arbitrates several error sources by fixed priority and records the faulting PC, cause code and error-target register index. It holds these in a small LIFO so nested exceptions unwind correctly on `eret`. It sits between the datapath error detectors and the main control FSM, replacing the single 5-bit error-target register.

## Interface
- `TGT_W`, 5: width of the error-target register index.
- `PC_W`, 32: width of captured PC.
- `N_SRC`, 4: number of error sources; index 0 has the highest priority.
- `DEPTH`, 4: LIFO entries; must be ≥1.
- `CAUSE_W`, derived `max(1, clog2(N_SRC))`: cause code width.
- `CNT_W`, derived `clog2(DEPTH+1)`: depth counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `err_valid`  in  N_SRC  per-source error strobe, one cycle.
- `err_target`  in  N_SRC*TGT_W  per-source target index; source i occupies bits [i*TGT_W +: TGT_W].
- `err_pc`  in  PC_W  PC of the faulting instruction, shared by all sources.
- `exc_req`  out  1  exception pending to the control FSM.
- `exc_cause`  out  CAUSE_W  index of the winning source, valid while `exc_req`.
- `exc_ack`  in  1  control FSM accepts the pending exception.
- `eret`  in  1  return from the current handler; pops one entry.
- `target_o`  out  TGT_W  target index of the top-of-stack entry.
- `epc_o`  out  PC_W  PC of the top-of-stack entry.
- `depth_o`  out  CNT_W  number of valid entries.
- `overflow`  out  1  sticky flag: an error was dropped because the stack was full.

## Operation
- FSM states: IDLE, REQ, SVC.
- **IDLE.** Any `err_valid` bit selects the lowest-index asserted source. Its {target, `err_pc`, cause} goes into the pending register, then the FSM moves to REQ.
- **REQ.** `exc_req`=1 and `exc_cause` = pending cause. The FSM holds until `exc_ack`.
  - On ack: push the pending entry, `depth_o`+1, go to SVC.
  - `err_valid` and `eret` are ignored in REQ. Pending is never overwritten.
- **SVC.** On `eret`, pop one entry. If depth reaches 0, go to IDLE.
  - `err_valid` with depth < DEPTH: a nested error is captured into pending and the FSM goes to REQ.
  - `err_valid` with depth = DEPTH: the error is dropped, `overflow` is set, and the FSM stays in SVC.
- **Simultaneous `eret` and `err_valid` in SVC.** The pop happens and the error is captured in the same cycle. The FSM goes to REQ even if depth reaches 0. The full check uses the post-pop depth, so no overflow is possible in this case.
- `eret` in IDLE or REQ is ignored; depth never underflows.
- `target_o`/`epc_o` show the top entry and read 0 when depth is 0.
- `overflow` clears only on reset.
- Width rules: stored values are zero-extended, with no truncation. `depth_o` saturates at DEPTH by construction.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE.
  - `exc_req`=0, `exc_cause`=0.
  - `target_o`=0, `epc_o`=0, `depth_o`=0, `overflow`=0.
  - All stack entries cleared.
- `err_valid` sampled at edge k → `exc_req`=1 and `exc_cause` valid after edge k. This is 1 cycle latency, all outputs registered.
- `exc_ack` sampled at edge m with `exc_req`=1:
  - `exc_req` falls after edge m.
  - `depth_o`, `target_o` and `epc_o` update after edge m.
- `eret` at edge n → pop visible after edge n.
- Reset asserted mid-handler discards all entries and pending state immediately.

## Configuration
- `ERR_SRC_MASK_EN` defined:
  - Adds input port `err_mask` [N_SRC], where 1 enables the source.
  - `err_valid` is ANDed with `err_mask` before arbitration.
  - A masked source can never win and never sets `overflow`.
- Not defined: no port, and all sources are always enabled.

## Structure
- Package `err_pkg`:
  - state enum {IDLE, REQ, SVC}.
  - entry struct {target, pc, cause}.
  - `CAUSE_W`/`CNT_W` helper functions.
- Sub-module `err_priority_enc`: combinational N_SRC-bit lowest-index priority encoder with outputs `any` and `idx`.
- The stack is a register array with a depth counter, inline in the top level.

## Test plan
- Single error: `err_valid`=4'b0100, `err_target`[2]=5'd9, `err_pc`=0x40 → next cycle `exc_req`=1, `exc_cause`=2. After `exc_ack`: `depth_o`=1, `target_o`=9, `epc_o`=0x40.
- Priority: `err_valid`=4'b1010 → `exc_cause`=1, and source 3 is not recorded.
- Nesting and unwind:
  - Two acked errors (PC 0x40, then 0x80) → `depth_o`=2, `epc_o`=0x80.
  - First `eret` → `epc_o`=0x40.
  - Second `eret` → `depth_o`=0, outputs 0, FSM in IDLE.
- Overflow: DEPTH=4, stack full, `err_valid` in SVC → `overflow`=1, `exc_req` stays 0, `depth_o`=4.
- Simultaneous: depth=1 in SVC, `eret` and `err_valid`=4'b0001 on the same edge → `depth_o`=0, `exc_req`=1, `exc_cause`=0. After ack, `depth_o`=1.
- Async reset while in REQ with depth 3 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/err_pkg.sv
// rtl/err_pkg.sv - shared types and width helpers for the exception-capture unit
package err_pkg;

  // Control sequencing: wait for an error, present it, service it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } err_state_t;

  // Captured exception record at the default core widths (5-bit target, 32-bit PC)
  typedef struct packed {
    logic [4:0]  target;
    logic [31:0] pc;
    logic [1:0]  cause;
  } err_entry_t;

  // Cause code width: enough bits to name every source, never less than one
  function automatic int calc_cause_w(input int n_src);
    calc_cause_w = (n_src <= 2) ? 1 : $clog2(n_src);
  endfunction

  // Depth counter width: must represent 0..DEPTH inclusive
  function automatic int calc_cnt_w(input int depth);
    calc_cnt_w = $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/err_priority_enc.sv
// rtl/err_priority_enc.sv - lowest-index-wins priority encoder for error sources
module err_priority_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest asserted index is the last assignment
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/error_target_stack.sv
// rtl/error_target_stack.sv - prioritised exception capture with nested LIFO unwind (option: ERR_SRC_MASK_EN)
module error_target_stack
  import err_pkg::*;
#(
  parameter int  TGT_W   = 5,
  parameter int  PC_W    = 32,
  parameter int  N_SRC   = 4,
  parameter int  DEPTH   = 4,
  localparam int CAUSE_W = calc_cause_w(N_SRC),
  localparam int CNT_W   = calc_cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       err_valid,
`ifdef ERR_SRC_MASK_EN
  input  logic [N_SRC-1:0]       err_mask,
`endif
  input  logic [N_SRC*TGT_W-1:0] err_target,
  input  logic [PC_W-1:0]        err_pc,
  output logic                   exc_req,
  output logic [CAUSE_W-1:0]     exc_cause,
  input  logic                   exc_ack,
  input  logic                   eret,
  output logic [TGT_W-1:0]       target_o,
  output logic [PC_W-1:0]        epc_o,
  output logic [CNT_W-1:0]       depth_o,
  output logic                   overflow
);

  err_state_t          state;
  logic [TGT_W-1:0]    pend_target;
  logic [PC_W-1:0]     pend_pc;
  logic [CNT_W-1:0]    depth;
  logic [TGT_W-1:0]    stk_target [DEPTH];
  logic [PC_W-1:0]     stk_pc     [DEPTH];

  logic [N_SRC-1:0]    src_req;
  logic                src_any;
  logic [CAUSE_W-1:0]  src_idx;
  logic [TGT_W-1:0]    src_target;
  logic                pop;
  logic [CNT_W-1:0]    depth_pop;

`ifdef ERR_SRC_MASK_EN
  // Disabled sources are removed before arbitration so they can neither win nor overflow
  assign src_req = err_valid & err_mask;
`else
  assign src_req = err_valid;
`endif

  err_priority_enc #(
    .N     (N_SRC),
    .IDX_W (CAUSE_W)
  ) u_prio (
    .req (src_req),
    .any (src_any),
    .idx (src_idx)
  );

  assign src_target = err_target[int'(src_idx)*TGT_W +: TGT_W];

  // Returns only count while servicing; the nested-error full check uses the post-pop depth
  assign pop       = (state == SVC) && eret;
  assign depth_pop = depth - CNT_W'(pop);
  assign depth_o   = depth;

  // Top-of-stack view; an empty stack reads as zero
  always_comb begin
    target_o = '0;
    epc_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == CNT_W'(i + 1)) begin
        target_o = stk_target[i];
        epc_o    = stk_pc[i];
      end
    end
  end

  // Capture / request / service sequencing with the stack and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      exc_req     <= 1'b0;
      exc_cause   <= '0;
      pend_target <= '0;
      pend_pc     <= '0;
      depth       <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_target[i] <= '0;
        stk_pc[i]     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (src_any) begin
            pend_target <= src_target;
            pend_pc     <= err_pc;
            exc_cause   <= src_idx;
            exc_req     <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          // Pending stays frozen here; new errors and returns are not looked at
          if (exc_ack) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (depth == CNT_W'(i)) begin
                stk_target[i] <= pend_target;
                stk_pc[i]     <= pend_pc;
              end
            end
            depth   <= depth + CNT_W'(1);
            exc_req <= 1'b0;
            state   <= SVC;
          end
        end
        SVC: begin
          if (pop) depth <= depth_pop;
          if (src_any && (depth_pop < CNT_W'(DEPTH))) begin
            pend_target <= src_target;
            pend_pc     <= err_pc;
            exc_cause   <= src_idx;
            exc_req     <= 1'b1;
            state       <= REQ;
          end else begin
            if (src_any) overflow <= 1'b1;
            if (pop && (depth_pop == '0)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_error_target_stack.sv
// tb/tb_error_target_stack.sv - directed self-checking bench for error_target_stack
module tb_error_target_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  err_valid;
`ifdef ERR_SRC_MASK_EN
  logic [3:0]  err_mask;
`endif
  logic [19:0] err_target;
  logic [31:0] err_pc;
  logic        exc_req;
  logic [1:0]  exc_cause;
  logic        exc_ack;
  logic        eret;
  logic [4:0]  target_o;
  logic [31:0] epc_o;
  logic [2:0]  depth_o;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  error_target_stack #(
    .TGT_W (5),
    .PC_W  (32),
    .N_SRC (4),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .err_valid  (err_valid),
`ifdef ERR_SRC_MASK_EN
    .err_mask   (err_mask),
`endif
    .err_target (err_target),
    .err_pc     (err_pc),
    .exc_req    (exc_req),
    .exc_cause  (exc_cause),
    .exc_ack    (exc_ack),
    .eret       (eret),
    .target_o   (target_o),
    .epc_o      (epc_o),
    .depth_o    (depth_o),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    err_valid = '0; err_target = '0; err_pc = '0; exc_ack = 1'b0; eret = 1'b0;
`ifdef ERR_SRC_MASK_EN
    err_mask = 4'hF;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One-edge error strobe; leaves the bench at the following falling edge
  task automatic raise_err(input logic [3:0] v, input logic [19:0] t, input logic [31:0] pc, input logic with_eret);
    err_valid = v; err_target = t; err_pc = pc; eret = with_eret;
    @(negedge clk);
    err_valid = '0; eret = 1'b0;
  endtask

  task automatic ack_once();
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
  endtask

  task automatic eret_once();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    err_valid = '0; err_target = '0; err_pc = '0; exc_ack = 1'b0; eret = 1'b0;
`ifdef ERR_SRC_MASK_EN
    err_mask = 4'hF;
`endif
    repeat (2) @(negedge clk);
    total++; if (exc_req !== 1'b0)  begin bad++; $display("FAIL reset_req got=%0d want=0", exc_req); end
    total++; if (exc_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d want=0", exc_cause); end
    total++; if (depth_o !== 3'd0)  begin bad++; $display("FAIL reset_depth got=%0d want=0", depth_o); end
    total++; if (target_o !== 5'd0 || epc_o !== 32'd0) begin bad++; $display("FAIL reset_top got=%0d/%h want=0/0", target_o, epc_o); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d want=0", overflow); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    eret_once();
    total++; if (depth_o !== 3'd0) begin bad++; $display("FAIL idle_eret_depth got=%0d want=0", depth_o); end
    raise_err(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 32'h40, 1'b0);
    total++; if (exc_req !== 1'b1 || exc_cause !== 2'd2) begin bad++; $display("FAIL single_req got=%0d/%0d want=1/2", exc_req, exc_cause); end
    total++; if (depth_o !== 3'd0) begin bad++; $display("FAIL single_predepth got=%0d want=0", depth_o); end
    ack_once();
    total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL single_reqdrop got=%0d want=0", exc_req); end
    total++; if (depth_o !== 3'd1 || target_o !== 5'd9 || epc_o !== 32'h40) begin bad++; $display("FAIL single_push got=%0d/%0d/%h want=1/9/40", depth_o, target_o, epc_o); end
    eret_once();
    total++; if (depth_o !== 3'd0 || target_o !== 5'd0 || epc_o !== 32'd0) begin bad++; $display("FAIL single_pop got=%0d/%0d/%h want=0/0/0", depth_o, target_o, epc_o); end
  endtask

  task automatic test_priority();
    apply_reset();
    raise_err(4'b1010, {5'd21, 5'd0, 5'd7, 5'd0}, 32'h100, 1'b0);
    total++; if (exc_req !== 1'b1 || exc_cause !== 2'd1) begin bad++; $display("FAIL prio_cause got=%0d/%0d want=1/1", exc_req, exc_cause); end
    raise_err(4'b0001, {5'd0, 5'd0, 5'd0, 5'd30}, 32'h200, 1'b1);
    total++; if (exc_cause !== 2'd1 || depth_o !== 3'd0) begin bad++; $display("FAIL prio_hold got=%0d/%0d want=1/0", exc_cause, depth_o); end
    ack_once();
    total++; if (target_o !== 5'd7 || epc_o !== 32'h100 || depth_o !== 3'd1) begin bad++; $display("FAIL prio_entry got=%0d/%h/%0d want=7/100/1", target_o, epc_o, depth_o); end
  endtask

  task automatic test_nesting();
    apply_reset();
    raise_err(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, 32'h40, 1'b0);
    ack_once();
    raise_err(4'b0010, {5'd0, 5'd0, 5'd4, 5'd0}, 32'h80, 1'b0);
    total++; if (exc_req !== 1'b1 || exc_cause !== 2'd1) begin bad++; $display("FAIL nest_req got=%0d/%0d want=1/1", exc_req, exc_cause); end
    ack_once();
    total++; if (depth_o !== 3'd2 || epc_o !== 32'h80 || target_o !== 5'd4) begin bad++; $display("FAIL nest_two got=%0d/%h/%0d want=2/80/4", depth_o, epc_o, target_o); end
    eret_once();
    total++; if (depth_o !== 3'd1 || epc_o !== 32'h40 || target_o !== 5'd3) begin bad++; $display("FAIL nest_pop1 got=%0d/%h/%0d want=1/40/3", depth_o, epc_o, target_o); end
    eret_once();
    total++; if (depth_o !== 3'd0 || epc_o !== 32'd0 || target_o !== 5'd0) begin bad++; $display("FAIL nest_pop2 got=%0d/%h/%0d want=0/0/0", depth_o, epc_o, target_o); end
    eret_once();
    total++; if (depth_o !== 3'd0 || exc_req !== 1'b0) begin bad++; $display("FAIL nest_underflow got=%0d/%0d want=0/0", depth_o, exc_req); end
    raise_err(4'b1000, {5'd17, 5'd0, 5'd0, 5'd0}, 32'hC0, 1'b0);
    total++; if (exc_req !== 1'b1 || exc_cause !== 2'd3) begin bad++; $display("FAIL nest_idle_again got=%0d/%0d want=1/3", exc_req, exc_cause); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      raise_err(4'b0001, {15'd0, 5'(i + 1)}, 32'(16 * (i + 1)), 1'b0);
      ack_once();
    end
    total++; if (depth_o !== 3'd4 || epc_o !== 32'h40 || target_o !== 5'd4) begin bad++; $display("FAIL ovf_full got=%0d/%h/%0d want=4/40/4", depth_o, epc_o, target_o); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0d want=0", overflow); end
    raise_err(4'b0001, {15'd0, 5'd31}, 32'h999, 1'b0);
    total++; if (overflow !== 1'b1 || exc_req !== 1'b0 || depth_o !== 3'd4) begin bad++; $display("FAIL ovf_drop got=%0d/%0d/%0d want=1/0/4", overflow, exc_req, depth_o); end
    total++; if (epc_o !== 32'h40) begin bad++; $display("FAIL ovf_top got=%h want=40", epc_o); end
    raise_err(4'b0100, {5'd0, 5'd12, 10'd0}, 32'h500, 1'b1);
    total++; if (depth_o !== 3'd3 || exc_req !== 1'b1 || exc_cause !== 2'd2) begin bad++; $display("FAIL ovf_popcap got=%0d/%0d/%0d want=3/1/2", depth_o, exc_req, exc_cause); end
    ack_once();
    total++; if (depth_o !== 3'd4 || epc_o !== 32'h500 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d/%h/%0d want=4/500/1", depth_o, epc_o, overflow); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    raise_err(4'b0010, {5'd0, 5'd0, 5'd6, 5'd0}, 32'h40, 1'b0);
    ack_once();
    raise_err(4'b0001, {15'd0, 5'd11}, 32'h90, 1'b1);
    total++; if (depth_o !== 3'd0 || exc_req !== 1'b1 || exc_cause !== 2'd0) begin bad++; $display("FAIL simul_cap got=%0d/%0d/%0d want=0/1/0", depth_o, exc_req, exc_cause); end
    total++; if (target_o !== 5'd0 || epc_o !== 32'd0) begin bad++; $display("FAIL simul_empty got=%0d/%h want=0/0", target_o, epc_o); end
    ack_once();
    total++; if (depth_o !== 3'd1 || target_o !== 5'd11 || epc_o !== 32'h90) begin bad++; $display("FAIL simul_ack got=%0d/%0d/%h want=1/11/90", depth_o, target_o, epc_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      raise_err(4'b0001, {15'd0, 5'(i + 2)}, 32'(256 + i), 1'b0);
      ack_once();
    end
    raise_err(4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, 32'h700, 1'b0);
    total++; if (depth_o !== 3'd3 || exc_req !== 1'b1) begin bad++; $display("FAIL areset_setup got=%0d/%0d want=3/1", depth_o, exc_req); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (exc_req !== 1'b0 || exc_cause !== 2'd0 || depth_o !== 3'd0) begin bad++; $display("FAIL areset_ctl got=%0d/%0d/%0d want=0/0/0", exc_req, exc_cause, depth_o); end
    total++; if (target_o !== 5'd0 || epc_o !== 32'd0 || overflow !== 1'b0) begin bad++; $display("FAIL areset_top got=%0d/%h/%0d want=0/0/0", target_o, epc_o, overflow); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (depth_o !== 3'd0 || exc_req !== 1'b0) begin bad++; $display("FAIL areset_after got=%0d/%0d want=0/0", depth_o, exc_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
